spi_target: RTL and testbench

SPI target (slave) byte shifter, SPI mode 0, MSB first: the peripheral end of the link that our SPI master shifter drives. It runs off the fabric clock and oversamples the external SCLK/MOSI/CS_n. It hands each received byte to the host side through a one-deep output register and takes transmit bytes from a one-deep input register, using the same full/req handshake as the master shifter. It is used to emulate an SPI device and to loop back the master in test.

---
 rtl/spi_target.sv | 175 +++++++++++++++++
 tb/tb_spi_target.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
// SPI mode-0 target byte shifter, MSB first, oversampling SCLK/MOSI/CS_n on the fabric clock.
// One-deep transmit and receive holding registers with full/req handshakes and sticky errors.
module spi_target #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       SCLK,
  input  logic       MOSI,
  input  logic       CS_n,
  output logic       MISO,
  output logic       MISO_oe,
  input  logic [7:0] data_in,
  input  logic       wr_req,
  output logic       in_full,
  output logic [7:0] data_out,
  input  logic       rd_req,
  output logic       out_full,
  output logic       overrun,
  output logic       underrun,
  input  logic       clr_err,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
  logic                   s_sclk, s_mosi, s_cs, s_sclk_d_q;
  logic                   rise, fall;

  state_e     state_q, state_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [6:0] rx_sr_q, rx_sr_d;
  logic [2:0] bit_count_q, bit_count_d;
  logic       byte_done_q, byte_done_d;
  logic [7:0] in_reg_q, in_reg_d;
  logic       in_full_q, in_full_d;
  logic [7:0] data_out_q, data_out_d;
  logic       out_full_q, out_full_d;
  logic       overrun_q, overrun_d;
  logic       underrun_q, underrun_d;
  logic       miso_q, miso_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      s_sclk_d_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS_n};
      s_sclk_d_q  <= s_sclk;
    end
  end

  assign s_sclk = sclk_sync_q[SYNC_STAGES-1];
  assign s_mosi = mosi_sync_q[SYNC_STAGES-1];
  assign s_cs   = cs_sync_q[SYNC_STAGES-1];
  assign rise   = s_sclk & ~s_sclk_d_q;
  assign fall   = ~s_sclk & s_sclk_d_q;

  always_comb begin
    state_d     = state_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    bit_count_d = bit_count_q;
    byte_done_d = byte_done_q;
    in_reg_d    = in_reg_q;
    in_full_d   = in_full_q;
    data_out_d  = data_out_q;
    out_full_d  = out_full_q;
    overrun_d   = overrun_q;
    underrun_d  = underrun_q;

    // Clear first so a coincident set event below wins.
    if (clr_err) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end
    if (rd_req) out_full_d = 1'b0;
    if (wr_req && !in_full_q) begin
      in_reg_d  = data_in;
      in_full_d = 1'b1;
    end

    if (s_cs) begin
      state_d     = StIdle;
      bit_count_d = 3'd0;
      byte_done_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StLoad;
        StLoad: begin
          if (in_full_q) begin
            tx_sr_d   = in_reg_q;
            in_full_d = 1'b0;
          end else begin
            tx_sr_d    = 8'hFF;
            underrun_d = 1'b1;
          end
          byte_done_d = 1'b0;
          state_d     = StShift;
        end
        StShift: begin
          if (rise) begin
            rx_sr_d     = {rx_sr_q[5:0], s_mosi};
            bit_count_d = bit_count_q + 3'd1;
            if (bit_count_q == 3'd7) begin
              byte_done_d = 1'b1;
              if (!out_full_q || rd_req) begin
                data_out_d = {rx_sr_q, s_mosi};
                out_full_d = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
            end
          end else if (fall) begin
            if (bit_count_q != 3'd0) begin
              tx_sr_d = {tx_sr_q[6:0], 1'b1};
            end else if (byte_done_q) begin
              byte_done_d = 1'b0;
              state_d     = StLoad;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // MISO tracks the next tx_sr so the first bit is valid right after LOAD.
    miso_d = (state_d == StIdle) ? 1'b1 : tx_sr_d[7];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      tx_sr_q     <= 8'hFF;
      rx_sr_q     <= '0;
      bit_count_q <= '0;
      byte_done_q <= 1'b0;
      in_reg_q    <= '0;
      in_full_q   <= 1'b0;
      data_out_q  <= '0;
      out_full_q  <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      miso_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      bit_count_q <= bit_count_d;
      byte_done_q <= byte_done_d;
      in_reg_q    <= in_reg_d;
      in_full_q   <= in_full_d;
      data_out_q  <= data_out_d;
      out_full_q  <= out_full_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
      miso_q      <= miso_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign MISO_oe  = busy;
  assign MISO     = miso_q;
  assign in_full  = in_full_q;
  assign data_out = data_out_q;
  assign out_full = out_full_q;
  assign overrun  = overrun_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: the bench plays the SPI master and the host side.
module tb_spi_target;

  localparam int H = 6;  // clk cycles per SCLK phase

  logic       clk = 1'b0;
  logic       reset_n;
  logic       SCLK, MOSI, CS_n;
  logic       MISO, MISO_oe;
  logic [7:0] data_in;
  logic       wr_req, in_full;
  logic [7:0] data_out;
  logic       rd_req, out_full;
  logic       overrun, underrun, clr_err, busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] got, got2;

  spi_target #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .CS_n     (CS_n),
    .MISO     (MISO),
    .MISO_oe  (MISO_oe),
    .data_in  (data_in),
    .wr_req   (wr_req),
    .in_full  (in_full),
    .data_out (data_out),
    .rd_req   (rd_req),
    .out_full (out_full),
    .overrun  (overrun),
    .underrun (underrun),
    .clr_err  (clr_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic host_wr(input logic [7:0] b);
    data_in = b;
    wr_req  = 1'b1;
    tick(1);
    wr_req  = 1'b0;
  endtask

  task automatic host_rd();
    rd_req = 1'b1;
    tick(1);
    rd_req = 1'b0;
  endtask

  task automatic host_clr();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
  endtask

  // Mode 0 master: MOSI changes with the falling edge, MISO sampled at the rising edge.
  // Leaves SCLK high after the last bit; rd_last pulses rd_req in the cycle the 8th rise is seen.
  task automatic xfer(input logic [7:0] tx, input int nbits, input bit rd_last,
                      output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = tx[7-i];
      tick(H);
      SCLK = 1'b1;
      rx = {rx[6:0], MISO};
      if (rd_last && i == 7) begin
        tick(2);
        rd_req = 1'b1;
        tick(1);
        rd_req = 1'b0;
        tick(H - 3);
      end else begin
        tick(H);
      end
    end
  endtask

  task automatic deselect();
    SCLK = 1'b0;
    tick(H);
    CS_n = 1'b1;
    tick(4);
  endtask

  initial begin
    reset_n = 1'b0;
    SCLK = 1'b0; MOSI = 1'b0; CS_n = 1'b1;
    data_in = 8'h00; wr_req = 1'b0; rd_req = 1'b0; clr_err = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(3);

    chk("rst_miso", {7'd0, MISO}, 8'h01);
    chk("rst_oe", {7'd0, MISO_oe}, 8'h00);
    chk("rst_in_full", {7'd0, in_full}, 8'h00);
    chk("rst_out_full", {7'd0, out_full}, 8'h00);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_errs", {6'd0, overrun, underrun}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);

    // Single byte
    host_wr(8'hA5);
    chk("single_in_full_set", {7'd0, in_full}, 8'h01);
    CS_n = 1'b0;
    xfer(8'h3C, 8, 1'b0, got);
    chk("single_miso_byte", got, 8'hA5);
    chk("single_data_out", data_out, 8'h3C);
    chk("single_out_full", {7'd0, out_full}, 8'h01);
    chk("single_in_full", {7'd0, in_full}, 8'h00);
    chk("single_errs", {6'd0, overrun, underrun}, 8'h00);
    chk("single_busy_oe", {6'd0, busy, MISO_oe}, 8'h03);
    deselect();
    host_clr();
    chk("single_idle", {5'd0, busy, MISO_oe, MISO}, 8'h01);
    chk("single_clr", {6'd0, overrun, underrun}, 8'h00);

    // Streaming
    host_rd();
    host_wr(8'h01);
    CS_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      xfer(8'hF0 + 8'(k), 8, 1'b0, got);
      chk("stream_tx", got, 8'(k + 1));
      chk("stream_rx", data_out, 8'hF0 + 8'(k));
      chk("stream_out_full", {7'd0, out_full}, 8'h01);
      data_in = 8'(k + 2);
      wr_req  = (k < 3);
      rd_req  = 1'b1;
      tick(1);
      wr_req  = 1'b0;
      rd_req  = 1'b0;
    end
    chk("stream_errs", {6'd0, overrun, underrun}, 8'h00);
    deselect();
    host_clr();

    // Underrun and overrun
    chk("uo_pre_out_full", {7'd0, out_full}, 8'h00);
    CS_n = 1'b0;
    xfer(8'h11, 8, 1'b0, got);
    xfer(8'h22, 8, 1'b0, got2);
    chk("uo_tx1_ff", got, 8'hFF);
    chk("uo_tx2_ff", got2, 8'hFF);
    deselect();
    chk("uo_underrun", {7'd0, underrun}, 8'h01);
    chk("uo_overrun", {7'd0, overrun}, 8'h01);
    chk("uo_data_out", data_out, 8'h11);
    chk("uo_out_full", {7'd0, out_full}, 8'h01);
    host_clr();
    chk("uo_clr", {6'd0, overrun, underrun}, 8'h00);

    // Abort after 5 bits
    host_wr(8'h5A);
    CS_n = 1'b0;
    xfer(8'hC3, 5, 1'b0, got);
    SCLK = 1'b0;
    tick(H);
    CS_n = 1'b1;
    tick(3);
    chk("abort_busy", {7'd0, busy}, 8'h00);
    chk("abort_oe_miso", {6'd0, MISO_oe, MISO}, 8'h01);
    chk("abort_out_full", {7'd0, out_full}, 8'h01);
    chk("abort_data_out", data_out, 8'h11);
    chk("abort_in_consumed", {7'd0, in_full}, 8'h00);
    host_rd();
    host_wr(8'h96);
    CS_n = 1'b0;
    xfer(8'h69, 8, 1'b0, got);
    chk("fresh_tx", got, 8'h96);
    chk("fresh_rx", data_out, 8'h69);

    // rd_req coincident with byte completion
    host_wr(8'h4B);
    xfer(8'hA3, 8, 1'b1, got);
    chk("simul_tx", got, 8'h4B);
    chk("simul_data_out", data_out, 8'hA3);
    chk("simul_out_full", {7'd0, out_full}, 8'h01);
    chk("simul_overrun", {7'd0, overrun}, 8'h00);

    // Reset mid-transfer
    xfer(8'h5C, 3, 1'b0, got);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mrst_miso_oe", {6'd0, MISO, MISO_oe}, 8'h02);
    chk("mrst_full", {6'd0, in_full, out_full}, 8'h00);
    chk("mrst_data_out", data_out, 8'h00);
    chk("mrst_errs", {6'd0, overrun, underrun}, 8'h00);
    chk("mrst_busy", {7'd0, busy}, 8'h00);
    SCLK = 1'b0;
    CS_n = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(6);
    chk("post_rst_idle", {6'd0, busy, MISO}, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
